sdram_multi_bridge: RTL and testbench
=====================================

Name: sdram_multi_bridge

Overview:
- Parametrised successor to the single-channel CPU-to-SDRAM request logic in the Oric top level.
- Converts NCH level-style memory interfaces (cs/oe/we) into toggle requests on one MiST SDRAM port. Typical clients are the CPU (channel 0) and the FDC or microdisc buffer (channel 1).
- Runs in the SDRAM clock domain (clk_72).
- Adds per-channel request capture, one-deep queuing, arbitration, byte-lane steering, per-channel read-data registers and busy/valid status.

Parameters:
- NCH, 2: number of client channels (1..8).
- AW, 16: client byte-address width.
- CHW, 1: channel-index width; must satisfy 2^CHW >= NCH.
- MAW, AW-1+CHW: SDRAM word-address width (derived; not overridable).

Ports:
- clk  in  1  SDRAM-domain clock (clk_72).
- reset_n  in  1  synchronous, active-low reset.
- ch_cs  in  NCH  per-channel chip select.
- ch_oe  in  NCH  per-channel read enable.
- ch_we  in  NCH  per-channel write enable.
- ch_a  in  NCH*AW  per-channel byte address; channel i occupies bits [i*AW +: AW].
- ch_d  in  NCH*8  per-channel write data.
- ch_q  out  NCH*8  per-channel read data register.
- ch_busy  out  NCH  channel has a pending or in-flight access.
- ch_valid  out  NCH  one-cycle pulse when that channel's read data is updated.
- mem_req  out  1  toggle request to SDRAM port.
- mem_ack  in  1  toggle acknowledge from SDRAM port.
- mem_a  out  MAW  word address = {channel index, ch_a[AW-1:1]}.
- mem_ds  out  2  byte-lane enables.
- mem_we  out  1  write request.
- mem_d  out  16  write data.
- mem_q  in  16  read data; valid in the cycle mem_ack becomes equal to mem_req.

Behaviour:
- Reset (reset_n=0 at clk edge):
  - mem_req=0, mem_we=0, mem_a=0, mem_ds=2'b11, mem_d=0.
  - All ch_q=0, ch_busy=0, ch_valid=0.
  - All pending/in-flight flags and edge-detect history cleared; FSM to IDLE.
  - The SDRAM controller shares this reset, so mem_ack is also 0 afterwards.
  - A reset mid-transfer abandons the transfer; no ch_q update or ch_valid pulse for it.
- Trigger detection, per channel, registered history of cs&oe, cs&we and address:
  - trig = rise(cs&oe) | rise(cs&we) | (cs&oe & ch_a != prev_a).
  - On trig, latch addr, d and we (we=cs&we) into the channel slot and set pending.
  - Simultaneous oe and we rise: treated as a write.
  - Trigger while pending and not yet granted: slot is overwritten (last wins); still one access.
  - Trigger while the channel is in flight: slot latches it as a new pending access (one-deep queue).
- FSM states:
  - IDLE: if any pending, grant one channel (see arbitration), then drive:
    - mem_a = {idx, addr[AW-1:1]}, mem_we = latched we, mem_d = {d,d};
    - mem_ds = we ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
    - toggle mem_req; clear that channel's pending, set its in-flight flag; go to WAIT.
  - WAIT: when mem_ack == mem_req:
    - for a read, ch_q[idx] = addr[0] ? mem_q[15:8] : mem_q[7:0] and ch_valid[idx] pulses for 1 cycle;
    - clear in-flight; go to IDLE.
  - Grant latency: a trigger registered in cycle n toggles mem_req at edge n+1 (IDLE, no contention). The next grant can occur on the edge after ack completion.
- Arbitration (default): fixed priority, lowest index wins.
- mem_a, mem_ds, mem_we and mem_d are stable from the mem_req toggle until completion.
- ch_busy[i] = pending[i] | inflight[i], registered.
- ch_q holds its value until the next completed read on that channel; writes never alter ch_q.
- No timeout: WAIT persists until ack.

Optional Feature:
- Macro SDRAM_BRIDGE_RR_EN.
- Defined: round-robin arbitration. The search starts at (last granted index + 1) mod NCH, so no channel waits more than NCH-1 grants.
- Undefined: fixed priority as described above. Channel 0 can starve others under continuous triggering.

Test Plan:
- Reset then idle, NCH=2: hold reset_n=0 for 3 cycles -> mem_req=0, ch_busy=2'b00, ch_q=0; no mem_req toggle for 100 cycles with cs=0.
- Ch0 read at 0x1235 with mem_q=16'hAB12 at ack -> mem_a=0x091A, mem_ds=2'b11, mem_we=0; ch_q[0]=8'hAB; ch_valid[0] pulses exactly 1 cycle.
- Ch1 write 0x5A at 0x0040 -> mem_a={1,15'h0020}, mem_ds=2'b01, mem_d=16'h5A5A, mem_we=1; ch_q[1] unchanged; no ch_valid pulse.
- Simultaneous triggers on ch0 and ch1:
  - macro undefined -> ch0 granted first, ch1 granted on the edge after ch0 completes;
  - with SDRAM_BRIDGE_RR_EN and last grant=0 -> ch1 first.
- Address change during in-flight ch0 read (0x0100 -> 0x0101, oe held) -> exactly two mem_req toggles; final ch_q[0] is the high byte of the second word.
- Reset asserted in WAIT before ack -> no ch_valid pulse; all ch_busy=0 the cycle after; FSM in IDLE.

Source files
------------

// File: rtl/sdram_multi_bridge.sv
// sdram_multi_bridge: NCH level-style (cs/oe/we) clients multiplexed onto one MiST SDRAM toggle port.
// Optional macro SDRAM_BRIDGE_RR_EN selects round-robin arbitration; default is fixed priority (ch0 highest).

module sdram_bridge_chan #(
  parameter int AW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          cs_i,
  input  logic          oe_i,
  input  logic          we_i,
  input  logic [AW-1:0] a_i,
  input  logic [7:0]    d_i,
  output logic          trig_o,
  output logic [AW-1:0] a_o,
  output logic [7:0]    d_o,
  output logic          we_o
);
  logic          rd, wr;
  logic          rd_q, wr_q, we_q;
  logic [AW-1:0] pa_q, a_q;
  logic [7:0]    d_q;

  assign rd = cs_i & oe_i;
  assign wr = cs_i & we_i;
  // A held read re-fires whenever the client moves its address.
  assign trig_o = (rd & ~rd_q) | (wr & ~wr_q) | (rd & (a_i != pa_q));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_q <= 1'b0;
      wr_q <= 1'b0;
      pa_q <= '0;
      a_q  <= '0;
      d_q  <= '0;
      we_q <= 1'b0;
    end else begin
      rd_q <= rd;
      wr_q <= wr;
      pa_q <= a_i;
      if (trig_o) begin
        a_q  <= a_i;
        d_q  <= d_i;
        we_q <= wr;
      end
    end
  end

  assign a_o  = a_q;
  assign d_o  = d_q;
  assign we_o = we_q;
endmodule

module sdram_multi_bridge #(
  parameter int NCH = 2,
  parameter int AW  = 16,
  parameter int CHW = 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NCH-1:0]       ch_cs,
  input  logic [NCH-1:0]       ch_oe,
  input  logic [NCH-1:0]       ch_we,
  input  logic [NCH*AW-1:0]    ch_a,
  input  logic [NCH*8-1:0]     ch_d,
  output logic [NCH*8-1:0]     ch_q,
  output logic [NCH-1:0]       ch_busy,
  output logic [NCH-1:0]       ch_valid,
  output logic                 mem_req,
  input  logic                 mem_ack,
  output logic [AW+CHW-2:0]    mem_a,
  output logic [1:0]           mem_ds,
  output logic                 mem_we,
  output logic [15:0]          mem_d,
  input  logic [15:0]          mem_q
);
  localparam int MAW = AW - 1 + CHW;

  typedef enum logic {IDLE, WAIT} state_e;
  state_e state_q, state_d;

  logic [NCH-1:0]         trig;
  logic [NCH-1:0][AW-1:0] slot_a;
  logic [NCH-1:0][7:0]    slot_d;
  logic [NCH-1:0]         slot_we;

  logic [NCH-1:0]       pend_q, pend_d, infl_q, infl_d, busy_q, vld_q, vld_d;
  logic [NCH-1:0][7:0]  chq_q, chq_d;
  logic                 req_q, req_d, we_q, we_d, lsb_q, lsb_d;
  logic [MAW-1:0]       a_q, a_d;
  logic [1:0]           ds_q, ds_d;
  logic [15:0]          d_q, d_d;
  logic [CHW-1:0]       idx_q, idx_d, gidx;

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    sdram_bridge_chan #(.AW(AW)) u_chan (
      .clk    (clk),
      .reset_n(reset_n),
      .cs_i   (ch_cs[i]),
      .oe_i   (ch_oe[i]),
      .we_i   (ch_we[i]),
      .a_i    (ch_a[i*AW +: AW]),
      .d_i    (ch_d[i*8 +: 8]),
      .trig_o (trig[i]),
      .a_o    (slot_a[i]),
      .d_o    (slot_d[i]),
      .we_o   (slot_we[i])
    );
  end

`ifdef SDRAM_BRIDGE_RR_EN
  logic [CHW-1:0] last_q;
  int             best;

  // Pick the pending channel closest after the last grant, wrapping mod NCH.
  always_comb begin
    gidx = '0;
    best = NCH;
    for (int c = 0; c < NCH; c++) begin
      if (pend_q[c] && ((c - int'(last_q) - 1 + 2*NCH) % NCH) < best) begin
        best = (c - int'(last_q) - 1 + 2*NCH) % NCH;
        gidx = CHW'(c);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n)                         last_q <= CHW'(NCH-1);
    else if (state_q == IDLE && |pend_q)  last_q <= gidx;
  end
`else
  always_comb begin
    gidx = '0;
    for (int c = NCH-1; c >= 0; c--)
      if (pend_q[c]) gidx = CHW'(c);
  end
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    a_d     = a_q;
    ds_d    = ds_q;
    d_d     = d_q;
    we_d    = we_q;
    lsb_d   = lsb_q;
    idx_d   = idx_q;
    pend_d  = pend_q;
    infl_d  = infl_q;
    chq_d   = chq_q;
    vld_d   = '0;
    case (state_q)
      IDLE: if (|pend_q) begin
        req_d        = ~req_q;
        a_d          = {gidx, slot_a[gidx][AW-1:1]};
        we_d         = slot_we[gidx];
        d_d          = {2{slot_d[gidx]}};
        ds_d         = slot_we[gidx] ? (slot_a[gidx][0] ? 2'b10 : 2'b01) : 2'b11;
        lsb_d        = slot_a[gidx][0];
        idx_d        = gidx;
        pend_d[gidx] = 1'b0;
        infl_d[gidx] = 1'b1;
        state_d      = WAIT;
      end
      WAIT: if (mem_ack == req_q) begin
        if (!we_q) begin
          chq_d[idx_q] = lsb_q ? mem_q[15:8] : mem_q[7:0];
          vld_d[idx_q] = 1'b1;
        end
        infl_d[idx_q] = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A fresh trigger re-arms the slot even on the cycle it is granted.
    pend_d = pend_d | trig;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      a_q     <= '0;
      ds_q    <= 2'b11;
      d_q     <= '0;
      we_q    <= 1'b0;
      lsb_q   <= 1'b0;
      idx_q   <= '0;
      pend_q  <= '0;
      infl_q  <= '0;
      busy_q  <= '0;
      chq_q   <= '0;
      vld_q   <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      a_q     <= a_d;
      ds_q    <= ds_d;
      d_q     <= d_d;
      we_q    <= we_d;
      lsb_q   <= lsb_d;
      idx_q   <= idx_d;
      pend_q  <= pend_d;
      infl_q  <= infl_d;
      busy_q  <= pend_d | infl_d;
      chq_q   <= chq_d;
      vld_q   <= vld_d;
    end
  end

  assign mem_req  = req_q;
  assign mem_a    = a_q;
  assign mem_ds   = ds_q;
  assign mem_we   = we_q;
  assign mem_d    = d_q;
  assign ch_q     = chq_q;
  assign ch_busy  = busy_q;
  assign ch_valid = vld_q;
endmodule

// File: tb/tb_sdram_multi_bridge.sv
// Bench for sdram_multi_bridge: directed cases plus randomized traffic checked every cycle against a behavioural model.
module tb_sdram_multi_bridge;
  localparam int NCH = 2, AW = 16, CHW = 1, MAW = AW - 1 + CHW;

  logic              clk = 1'b0, reset_n = 1'b0;
  logic [NCH-1:0]    ch_cs = '0, ch_oe = '0, ch_we = '0;
  logic [NCH*AW-1:0] ch_a = '0;
  logic [NCH*8-1:0]  ch_d = '0;
  logic [NCH*8-1:0]  ch_q;
  logic [NCH-1:0]    ch_busy, ch_valid;
  logic              mem_req, mem_we;
  logic              mem_ack = 1'b0;
  logic [MAW-1:0]    mem_a;
  logic [1:0]        mem_ds;
  logic [15:0]       mem_d;
  logic [15:0]       mem_q = 16'h0;

  sdram_multi_bridge #(.NCH(NCH), .AW(AW), .CHW(CHW)) dut (
    .clk(clk), .reset_n(reset_n), .ch_cs(ch_cs), .ch_oe(ch_oe), .ch_we(ch_we),
    .ch_a(ch_a), .ch_d(ch_d), .ch_q(ch_q), .ch_busy(ch_busy), .ch_valid(ch_valid),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_a(mem_a), .mem_ds(mem_ds),
    .mem_we(mem_we), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // SDRAM port responder: acks each toggle after a delay, presenting mem_q with the ack.
  logic [15:0] rsp_fix_q = 16'h0;
  int          rsp_fix_dly = 2, rsp_cnt = -1;
  bit          rsp_rand = 1'b0;
  initial forever begin
    @(posedge clk); #1;
    if (!reset_n) begin
      mem_ack = 1'b0;
      rsp_cnt = -1;
    end else if (mem_req != mem_ack) begin
      if (rsp_cnt < 0) rsp_cnt = rsp_rand ? int'($urandom_range(0, 4)) : rsp_fix_dly;
      if (rsp_cnt == 0) begin
        mem_q   = rsp_rand ? 16'($urandom) : rsp_fix_q;
        mem_ack = mem_req;
        rsp_cnt = -1;
      end else rsp_cnt--;
    end
  end

  // Behavioural model: per-channel slot + pending flag, one transfer at a time.
  logic [NCH-1:0] m_prd, m_pwr, m_pend, m_valid, m_busy, m_trig;
  logic [AW-1:0]  m_pa[NCH], m_sa[NCH];
  logic [7:0]     m_sd[NCH], m_chq[NCH];
  logic           m_swe[NCH];
  bit             m_active, m_cwe, m_lsb, started = 1'b0;
  int             m_cur, m_last, m_g;
  logic           m_req, m_we, t_rd, t_wr;
  logic [MAW-1:0] m_a;
  logic [1:0]     m_ds;
  logic [15:0]    m_d;
  logic [AW-1:0]  t_a;

  function automatic int pick(input logic [NCH-1:0] p, input int last);
`ifdef SDRAM_BRIDGE_RR_EN
    for (int k = 1; k <= NCH; k++) if (p[(last + k) % NCH]) return (last + k) % NCH;
`else
    for (int k = 0; k < NCH; k++) if (p[k]) return k;
`endif
    return 0;
  endfunction

  initial forever begin
    @(posedge clk);
    if (!reset_n) begin
      m_prd = '0; m_pwr = '0; m_pend = '0; m_valid = '0; m_busy = '0;
      for (int i = 0; i < NCH; i++) begin
        m_pa[i] = '0; m_sa[i] = '0; m_sd[i] = '0; m_chq[i] = '0; m_swe[i] = 1'b0;
      end
      m_active = 1'b0; m_cur = 0; m_last = NCH - 1;
      m_req = 1'b0; m_we = 1'b0; m_a = '0; m_ds = 2'b11; m_d = '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        t_rd = ch_cs[i] & ch_oe[i];
        t_wr = ch_cs[i] & ch_we[i];
        t_a  = ch_a[i*AW +: AW];
        m_trig[i] = (t_rd && !m_prd[i]) || (t_wr && !m_pwr[i]) || (t_rd && t_a != m_pa[i]);
      end
      m_valid = '0;
      if (m_active) begin
        if (mem_ack == m_req) begin
          if (!m_cwe) begin
            m_chq[m_cur]   = m_lsb ? mem_q[15:8] : mem_q[7:0];
            m_valid[m_cur] = 1'b1;
          end
          m_active = 1'b0;
        end
      end else if (m_pend != '0) begin
        m_g = pick(m_pend, m_last);
        m_last = m_g; m_cur = m_g; m_active = 1'b1;
        m_req = ~m_req;
        m_a   = MAW'(m_g * (2 ** (AW - 1)) + int'(m_sa[m_g] >> 1));
        m_we  = m_swe[m_g];
        m_d   = {m_sd[m_g], m_sd[m_g]};
        m_ds  = m_swe[m_g] ? (m_sa[m_g][0] ? 2'b10 : 2'b01) : 2'b11;
        m_lsb = m_sa[m_g][0];
        m_cwe = m_swe[m_g];
        m_pend[m_g] = 1'b0;
      end
      for (int i = 0; i < NCH; i++) begin
        t_rd = ch_cs[i] & ch_oe[i];
        t_wr = ch_cs[i] & ch_we[i];
        t_a  = ch_a[i*AW +: AW];
        if (m_trig[i]) begin
          m_sa[i] = t_a; m_sd[i] = ch_d[i*8 +: 8]; m_swe[i] = t_wr; m_pend[i] = 1'b1;
        end
        m_prd[i] = t_rd; m_pwr[i] = t_wr; m_pa[i] = t_a;
      end
      m_busy = m_pend;
      if (m_active) m_busy[m_cur] = 1'b1;
    end
    started = 1'b1;
  end

  // Every-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (started) begin
      chk("mem_req", mem_req, m_req);
      chk("mem_a", mem_a, m_a);
      chk("mem_ds", mem_ds, m_ds);
      chk("mem_we", mem_we, m_we);
      chk("mem_d", mem_d, m_d);
      chk("ch_busy", ch_busy, m_busy);
      chk("ch_valid", ch_valid, m_valid);
      for (int i = 0; i < NCH; i++) chk("ch_q", ch_q[i*8 +: 8], m_chq[i]);
    end
  end

  // Event counters for directed checks.
  int   tcnt = 0;
  int   vcnt[NCH];
  logic last_req = 1'b0;
  initial begin
    for (int i = 0; i < NCH; i++) vcnt[i] = 0;
    forever begin
      @(negedge clk);
      if (mem_req !== last_req) tcnt++;
      last_req = mem_req;
      for (int i = 0; i < NCH; i++) if (ch_valid[i] === 1'b1) vcnt[i]++;
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask
  task automatic sample();
    @(negedge clk); #1;
  endtask
  task automatic set_ch(input int i, input bit cs, input bit oe, input bit we,
                        input logic [AW-1:0] a, input logic [7:0] d);
    ch_cs[i] = cs; ch_oe[i] = oe; ch_we[i] = we;
    ch_a[i*AW +: AW] = a;
    ch_d[i*8 +: 8] = d;
  endtask
  task automatic wait_quiet();
    int n = 0;
    do begin sample(); n++; end while ((ch_busy != '0 || mem_req != mem_ack) && n < 200);
    chk("quiet_timeout", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int t0, v0, v1, n, first, other;
  initial begin
    // Reset, then idle
    reset_n = 1'b0;
    repeat (3) step();
    sample();
    chk("rst_mem_req", mem_req, 0);
    chk("rst_busy", ch_busy, 0);
    chk("rst_ch_q", ch_q, 0);
    chk("rst_mem_ds", mem_ds, 2'b11);
    chk("rst_valid", ch_valid, 0);
    step(); reset_n = 1'b1;
    t0 = tcnt;
    repeat (100) step();
    chk("idle_toggles", tcnt - t0, 0);

    // Ch1 write 0x5A at 0x0040
    rsp_fix_dly = 3; t0 = tcnt; v1 = vcnt[1];
    set_ch(1, 1, 0, 1, 16'h0040, 8'h5A);
    step(); step(); sample();
    chk("wr_toggle", tcnt - t0, 1);
    chk("wr_mem_a", mem_a, 16'h8020);
    chk("wr_mem_ds", mem_ds, 2'b01);
    chk("wr_mem_d", mem_d, 16'h5A5A);
    chk("wr_mem_we", mem_we, 1);
    set_ch(1, 0, 0, 0, 16'h0040, 8'h5A);
    wait_quiet();
    chk("wr_ch_q1", ch_q[15:8], 8'h00);
    chk("wr_no_valid", vcnt[1] - v1, 0);

    // Ch0 read at 0x1235
    rsp_fix_q = 16'hAB12; t0 = tcnt; v0 = vcnt[0];
    set_ch(0, 1, 1, 0, 16'h1235, 8'h00);
    step(); step(); sample();
    chk("rd_toggle", tcnt - t0, 1);
    chk("rd_mem_a", mem_a, 16'h091A);
    chk("rd_model_a", m_a, 16'h091A);
    chk("rd_mem_ds", mem_ds, 2'b11);
    chk("rd_mem_we", mem_we, 0);
    wait_quiet();
    chk("rd_ch_q0", ch_q[7:0], 8'hAB);
    chk("rd_model_q0", m_chq[0], 8'hAB);
    chk("rd_valid_cycles", vcnt[0] - v0, 1);
    set_ch(0, 0, 0, 0, 16'h1235, 8'h00);

    // Simultaneous triggers; last grant was ch0
`ifdef SDRAM_BRIDGE_RR_EN
    first = 1;
`else
    first = 0;
`endif
    other = 1 - first;
    rsp_fix_dly = 2; rsp_fix_q = 16'h5566;
    set_ch(0, 1, 1, 0, 16'h0200, 8'h00);
    set_ch(1, 1, 1, 0, 16'h0301, 8'h00);
    step(); step(); sample();
    chk("sim_first", mem_a[MAW-1], first);
    t0 = tcnt; n = 0;
    while (ch_valid[first] !== 1'b1 && n < 40) begin sample(); n++; end
    chk("sim_done_timeout", 32'(n < 40), 32'd1);
    chk("sim_no_early_grant", tcnt - t0, 0);
    sample();
    chk("sim_second_toggle", tcnt - t0, 1);
    chk("sim_second", mem_a[MAW-1], other);
    wait_quiet();
    set_ch(0, 0, 0, 0, 16'h0200, 8'h00);
    set_ch(1, 0, 0, 0, 16'h0301, 8'h00);

    // Address change while ch0 read is in flight
    rsp_fix_q = 16'hC37E; rsp_fix_dly = 4; t0 = tcnt; v0 = vcnt[0];
    set_ch(0, 1, 1, 0, 16'h0100, 8'h00);
    step(); step(); step();
    set_ch(0, 1, 1, 0, 16'h0101, 8'h00);
    wait_quiet();
    chk("ach_toggles", tcnt - t0, 2);
    chk("ach_ch_q0", ch_q[7:0], 8'hC3);
    chk("ach_valids", vcnt[0] - v0, 2);
    set_ch(0, 0, 0, 0, 16'h0101, 8'h00);

    // Reset while waiting for ack
    rsp_fix_dly = 20; v0 = vcnt[0];
    set_ch(0, 1, 1, 0, 16'h0400, 8'h00);
    step(); step(); step(); step();
    reset_n = 1'b0;
    step(); sample();
    chk("rstw_busy", ch_busy, 0);
    chk("rstw_req", mem_req, 0);
    chk("rstw_no_valid", vcnt[0] - v0, 0);
    set_ch(0, 0, 0, 0, 16'h0400, 8'h00);
    step(); reset_n = 1'b1;
    rsp_fix_dly = 1; t0 = tcnt;
    set_ch(0, 1, 1, 0, 16'h0402, 8'h00);
    step(); step(); sample();
    chk("rstw_idle_grant", tcnt - t0, 1);
    wait_quiet();
    set_ch(0, 0, 0, 0, 16'h0402, 8'h00);

    // Randomized traffic
    rsp_rand = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NCH; i++)
        if ($urandom_range(0, 5) == 0)
          set_ch(i, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 2) == 0), 16'($urandom_range(0, 7)), 8'($urandom));
      reset_n = ($urandom_range(0, 999) != 0);
      step();
    end
    reset_n = 1'b1;
    ch_cs = '0; ch_oe = '0; ch_we = '0;
    wait_quiet();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
